seg_scan_ctrl: RTL

//  Sequencer for the 8-digit 7-segment display path of the MIPS CPU board.
//  - Time-multiplexes the 8 tubes: drives the digit index, the active-low anode strobe and the selected data nibble.
//  - Runs the banner-mode FSM: the shift_a mode, the count_flag reveal animation and the one-hot shift_b page select.
//  - Sits between the CPU debug/status outputs and the per-digit segment decoder.

---
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Sequencer for the 8-digit 7-segment display: tube scanning, the banner
//   reveal FSM and the debounced one-hot page select.
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   disp_data   32-bit value shown in normal mode, nibble k on tube k
//   banner_req  level, 1 = banner mode (synchronous to clk)
//   page_btn    raw asynchronous page push-button
//   tube_num    index of the lit tube (registered)
//   an          active-low one-hot anode strobes (registered)
//   data        nibble of disp_data for tube_num (combinational)
//   shift_a     2'b11 in banner states, 2'b00 in NORMAL (registered)
//   shift_b     one-hot banner page (registered)
//   count_flag  reveal progress 0..3 (registered)
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned ANIM_DIV = 50000000,
    parameter int unsigned DEBOUNCE = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp_data,
    input  logic        banner_req,
    input  logic        page_btn,
    output logic [2:0]  tube_num,
    output logic [7:0]  an,
    output logic [3:0]  data,
    output logic [1:0]  shift_a,
    output logic [3:0]  shift_b,
    output logic [1:0]  count_flag
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned ANIM_W = $clog2(ANIM_DIV);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE - 1);

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_REVEAL = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        tube_num_q, tube_num_d;
    logic [7:0]        an_q, an_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        shift_b_q, shift_b_d;
    logic [ANIM_W-1:0] anim_cnt_q, anim_cnt_d;
    logic [1:0]        count_flag_q, count_flag_d;
    logic [1:0]        shift_a_q, shift_a_d;
    logic              page_edge;

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            scan_cnt_q   <= '0;
            tube_num_q   <= 3'd0;
            an_q         <= 8'hFE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            deb_cnt_q    <= '0;
            shift_b_q    <= 4'b0001;
            anim_cnt_q   <= '0;
            count_flag_q <= 2'd0;
            shift_a_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            scan_cnt_q   <= scan_cnt_d;
            tube_num_q   <= tube_num_d;
            an_q         <= an_d;
            sync1_q      <= page_btn;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            deb_cnt_q    <= deb_cnt_d;
            shift_b_q    <= shift_b_d;
            anim_cnt_q   <= anim_cnt_d;
            count_flag_q <= count_flag_d;
            shift_a_q    <= shift_a_d;
        end
    end

    // Tube scan: anode pattern is computed from the next index so both
    // registers always change on the same edge
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        tube_num_d = tube_num_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            tube_num_d = tube_num_q + 3'd1;
        end
        an_d = ~(8'b0000_0001 << tube_num_d);
    end

    // Live nibble select for the lit tube
    always_comb begin
        data = 4'h0;
        case (tube_num_q)
            3'd0: data = disp_data[3:0];
            3'd1: data = disp_data[7:4];
            3'd2: data = disp_data[11:8];
            3'd3: data = disp_data[15:12];
            3'd4: data = disp_data[19:16];
            3'd5: data = disp_data[23:20];
            3'd6: data = disp_data[27:24];
            default: data = disp_data[31:28];
        endcase
    end

    // Page button: rising edge of the synchronised copy, dropped while the
    // lockout window is open
    assign page_edge = sync2_q & ~sync3_q;

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        shift_b_d = shift_b_q;
        if (deb_cnt_q != '0) begin
            deb_cnt_d = deb_cnt_q - DEB_W'(1);
        end else if (page_edge) begin
            deb_cnt_d = DEB_LOAD;
            shift_b_d = {shift_b_q[2:0], shift_b_q[3]};
        end
    end

    // Banner FSM next state and registered mode outputs
    always_comb begin
        state_d      = state_q;
        anim_cnt_d   = '0;
        count_flag_d = 2'd0;
        shift_a_d    = 2'b00;
        case (state_q)
            ST_NORMAL: begin
                if (banner_req) begin
                    state_d   = ST_REVEAL;
                    shift_a_d = 2'b11;
                end
            end
            ST_REVEAL: begin
                if (!banner_req) begin
                    state_d = ST_NORMAL;
                end else begin
                    shift_a_d    = 2'b11;
                    count_flag_d = count_flag_q;
                    anim_cnt_d   = anim_cnt_q + ANIM_W'(1);
                    if (anim_cnt_q == ANIM_LAST) begin
                        anim_cnt_d   = '0;
                        count_flag_d = count_flag_q + 2'd1;
                        if (count_flag_q == 2'd2) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!banner_req) begin
                    state_d = ST_NORMAL;
                end else begin
                    shift_a_d    = 2'b11;
                    count_flag_d = 2'd3;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    assign tube_num   = tube_num_q;
    assign an         = an_q;
    assign shift_a    = shift_a_q;
    assign shift_b    = shift_b_q;
    assign count_flag = count_flag_q;

endmodule
